burst_memory_responder: RTL

BURST_MEMORY_RESPONDER -- requirements
Module: burst_memory_responder

---
 rtl/burst_memory_responder_pkg.sv | 22 ++
 rtl/burst_memory_responder_mem_array.sv | 40 ++++
 rtl/burst_memory_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/burst_memory_responder_pkg.sv
// -----------------------------------------------------------------------------
// burst_memory_responder_pkg
// Shared definitions for the burst memory responder: FSM state encoding and
// the fixed line/beat geometry (a 256-bit line moved as four 64-bit beats).
// -----------------------------------------------------------------------------
package burst_memory_responder_pkg;

    localparam int BEAT_COUNT       = 4;
    localparam int BEAT_WIDTH       = 64;
    localparam int LINE_WIDTH       = 256;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int BEAT_IDX_W       = $clog2(BEAT_COUNT);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT        = 3'd1,
        READ_BURST  = 3'd2,
        WRITE_BURST = 3'd3,
        RECOVER     = 3'd4
    } state_e;

endpackage

// File: rtl/burst_memory_responder_mem_array.sv
// -----------------------------------------------------------------------------
// burst_mem_array
// Beat-granular line storage: NUM_LINES lines of four 64-bit beats each,
// addressed as {line, beat}. One synchronous write port, one combinational
// read port. Contents are never reset.
//
// Ports:
//   clk      clock for the write port
//   we_i     write enable, commits wdata_i at the rising edge
//   waddr_i  write address {line, beat}
//   wdata_i  write beat data
//   raddr_i  read address {line, beat}
//   rdata_o  read beat data (combinational)
// -----------------------------------------------------------------------------
module burst_mem_array
    import burst_memory_responder_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic                                      clk,
    input  logic                                      we_i,
    input  logic [$clog2(NUM_LINES*BEAT_COUNT)-1:0]   waddr_i,
    input  logic [BEAT_WIDTH-1:0]                     wdata_i,
    input  logic [$clog2(NUM_LINES*BEAT_COUNT)-1:0]   raddr_i,
    output logic [BEAT_WIDTH-1:0]                     rdata_o
);

    localparam int DEPTH = NUM_LINES * (LINE_WIDTH / BEAT_WIDTH);

    logic [BEAT_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/burst_memory_responder.sv
// -----------------------------------------------------------------------------
// burst_memory_responder
// Line-oriented memory target. A read or write request held in IDLE is
// accepted, waits LATENCY cycles, then moves a 256-bit line as four 64-bit
// beats (one per cycle, resp_o strobing), spends one RECOVER cycle, and
// returns to IDLE.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset (storage is not reset)
//   address_i  line address; bits [4:0] ignored, upper bits alias
//   read_i     read request level, held until the burst completes
//   write_i    write request level, held through all write beats
//   burst_i    write beat data, sampled on each write-beat edge
//   burst_o    read beat data during read beats, zero otherwise
//   resp_o     beat strobe, high for the four beat cycles
//   busy_o     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module burst_memory_responder
    import burst_memory_responder_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [BEAT_WIDTH-1:0] burst_i,
    output logic [BEAT_WIDTH-1:0] burst_o,
    output logic                  resp_o,
    output logic                  busy_o
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int ADDR_W = IDX_W + BEAT_IDX_W;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e                  state_q;
    logic [LAT_W-1:0]        lat_cnt_q;
    logic [BEAT_IDX_W-1:0]   beat_q;
    logic [IDX_W-1:0]        line_q;
    logic                    dir_write_q;
    logic                    resp_q;
    logic                    busy_q;

    logic                    rd_req;
    logic                    wr_req;
    logic                    req_held;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [BEAT_WIDTH-1:0]   mem_rdata;

    // Only the line-index field of the address matters.
    logic unused_addr;
    assign unused_addr = ^{address_i[31:LINE_OFFSET_BITS+IDX_W],
                           address_i[LINE_OFFSET_BITS-1:0]};

    // Simultaneous read and write is not a valid request.
    assign rd_req = read_i & ~write_i;
    assign wr_req = write_i & ~read_i;

    // Request level that must stay asserted while waiting for the burst.
    assign req_held = dir_write_q ? write_i : read_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            beat_q    <= '0;
            resp_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        line_q      <= address_i[LINE_OFFSET_BITS +: IDX_W];
                        dir_write_q <= wr_req;
                        busy_q      <= 1'b1;
                        beat_q      <= '0;
                        if (LATENCY == 1) begin
                            state_q   <= wr_req ? WRITE_BURST : READ_BURST;
                            resp_q    <= 1'b1;
                            lat_cnt_q <= '0;
                        end else begin
                            state_q   <= WAIT;
                            lat_cnt_q <= LAT_W'(LATENCY - 1);
                        end
                    end
                end

                WAIT: begin
                    // A withdrawn request abandons the transaction before any
                    // beat, even on the last waiting cycle.
                    if (!req_held) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        lat_cnt_q <= '0;
                    end else if (lat_cnt_q == LAT_W'(1)) begin
                        state_q   <= dir_write_q ? WRITE_BURST : READ_BURST;
                        resp_q    <= 1'b1;
                        lat_cnt_q <= '0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                    end
                end

                READ_BURST, WRITE_BURST: begin
                    // Bursts run to completion regardless of request levels.
                    beat_q <= beat_q + BEAT_IDX_W'(1);
                    if (beat_q == BEAT_IDX_W'(BEAT_COUNT - 1)) begin
                        state_q <= RECOVER;
                        resp_q  <= 1'b0;
                    end
                end

                RECOVER: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q   <= IDLE;
                    lat_cnt_q <= '0;
                    beat_q    <= '0;
                    resp_q    <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // A beat presented on a reset edge is not committed.
    assign mem_we   = ~rst & (state_q == WRITE_BURST);
    assign mem_addr = {line_q, beat_q};

    burst_mem_array #(
        .NUM_LINES (NUM_LINES)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_addr),
        .wdata_i (burst_i),
        .raddr_i (mem_addr),
        .rdata_o (mem_rdata)
    );

    assign burst_o = (state_q == READ_BURST) ? mem_rdata : '0;
    assign resp_o  = resp_q;
    assign busy_o  = busy_q;

endmodule
